// File: rtl/secure_reg_access_ctrl_if.sv
// Request/response handshake bundle between a requester and secure_reg_access_ctrl.
// The master modport is the requester side and the slave modport is the gatekeeper side.
interface secure_reg_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [TID_WIDTH-1:0]  req_tid;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_tid, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_tid, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/secure_reg_access_ctrl.sv
// Access gatekeeper in front of the secure register: only thread 0 may reach it while unlocked.
// Optional macro SECURE_REG_VIOL_LOG_EN adds viol_tid/viol_write logging of the last denial.
module secure_reg_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TID_WIDTH      = 4,
  parameter int VIOL_CNT_WIDTH = 8,
  parameter int LOCKOUT_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  secure_reg_access_ctrl_if.slave   bus,
  output logic                      reg_access_en,
  output logic                      reg_wr_en,
  output logic [TID_WIDTH-1:0]      reg_thread_id,
  output logic [DATA_WIDTH-1:0]     reg_data_in,
  input  logic [DATA_WIDTH-1:0]     reg_data_out,
  output logic [VIOL_CNT_WIDTH-1:0] viol_count,
`ifdef SECURE_REG_VIOL_LOG_EN
  output logic [TID_WIDTH-1:0]      viol_tid,
  output logic                      viol_write,
`endif
  output logic                      locked
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ACCESS,
    RESP
  } state_t;

  state_t                  state;
  logic [TID_WIDTH-1:0]    cap_tid;
  logic                    cap_write;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [VIOL_CNT_WIDTH-1:0] viol_next;

  // The counter saturates; lockout is judged on the value after this denial is counted.
  assign viol_next = (&viol_count) ? viol_count : viol_count + VIOL_CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      reg_access_en  <= 1'b0;
      reg_wr_en      <= 1'b0;
      reg_thread_id  <= '0;
      reg_data_in    <= '0;
      viol_count     <= '0;
      locked         <= 1'b0;
      cap_tid        <= '0;
      cap_write      <= 1'b0;
      cap_wdata      <= '0;
`ifdef SECURE_REG_VIOL_LOG_EN
      viol_tid       <= '0;
      viol_write     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_tid       <= bus.req_tid;
            cap_write     <= bus.req_write;
            cap_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            state         <= CHECK;
          end
        end

        CHECK: begin
          if (cap_tid == '0 && !locked) begin
            reg_access_en <= 1'b1;
            reg_wr_en     <= cap_write;
            reg_thread_id <= cap_tid;
            reg_data_in   <= cap_wdata;
            state         <= ACCESS;
          end else begin
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_valid <= 1'b1;
            viol_count     <= viol_next;
            if (viol_next >= VIOL_CNT_WIDTH'(LOCKOUT_THRESH)) begin
              locked <= 1'b1;
            end
`ifdef SECURE_REG_VIOL_LOG_EN
            viol_tid       <= cap_tid;
            viol_write     <= cap_write;
`endif
            state          <= RESP;
          end
        end

        // The register is enabled for exactly this one cycle; read data is sampled on the way out.
        ACCESS: begin
          reg_access_en  <= 1'b0;
          reg_wr_en      <= 1'b0;
          reg_thread_id  <= '0;
          reg_data_in    <= '0;
          bus.resp_rdata <= cap_write ? '0 : reg_data_out;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
